// File: rtl/program_loader.sv
// Boot-time instruction memory loader: byte stream in, 32-bit MSB-first words out
// to sequential word addresses from 0, then releases the processor via cpu_run.
module program_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [WORD_WIDTH-1:0] imem_wdata,
  output logic [ADDR_WIDTH:0]   words_loaded,
  output logic                  cpu_run,
  output logic                  load_error
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_LOAD,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

  state_e                state_q;
  logic [7:0]            n_hi_q;
  logic [15:0]           n_q;
  logic [1:0]            byte_idx_q;
  logic [23:0]           shift_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  imem_we_q;
  logic [ADDR_WIDTH-1:0] imem_addr_q;
  logic [WORD_WIDTH-1:0] imem_wdata_q;
  logic [ADDR_WIDTH:0]   words_q;
  logic                  cpu_run_q;
  logic                  load_error_q;

  logic                  accept;
  logic [15:0]           n_d;
  logic [ADDR_WIDTH:0]   words_d;

  always_comb begin
    in_ready = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) || (state_q == S_LOAD);
    accept   = in_valid && in_ready;
    n_d      = {n_hi_q, in_data};
    words_d  = words_q + 1'b1;
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign words_loaded = words_q;
  assign cpu_run      = cpu_run_q;
  assign load_error   = load_error_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_HDR_HI;
      n_hi_q       <= '0;
      n_q          <= '0;
      byte_idx_q   <= '0;
      shift_q      <= '0;
      idx_q        <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      words_q      <= '0;
      cpu_run_q    <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        S_HDR_HI: if (accept) begin
          n_hi_q  <= in_data;
          state_q <= S_HDR_LO;
        end
        S_HDR_LO: if (accept) begin
          n_q <= n_d;
          if (n_d == 16'd0) begin
            state_q <= S_DONE;
          end else if ({1'b0, n_d} > DEPTH) begin
            state_q      <= S_ERROR;
            load_error_q <= 1'b1;
          end else begin
            state_q    <= S_LOAD;
            byte_idx_q <= '0;
            idx_q      <= '0;
          end
        end
        S_LOAD: if (accept) begin
          byte_idx_q <= byte_idx_q + 2'd1;
          shift_q    <= {shift_q[15:0], in_data};
          // The 4th byte goes straight into the word, so the strobe lands one cycle later.
          if (byte_idx_q == 2'd3) begin
            imem_we_q    <= 1'b1;
            imem_addr_q  <= idx_q;
            imem_wdata_q <= {shift_q, in_data};
            idx_q        <= idx_q + 1'b1;
            words_q      <= words_d;
            if (16'(words_d) == n_q) state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (reload) begin
            state_q    <= S_HDR_HI;
            cpu_run_q  <= 1'b0;
            words_q    <= '0;
            byte_idx_q <= '0;
          end else begin
            cpu_run_q <= 1'b1;
          end
        end
        S_ERROR: begin
          if (reload) begin
            state_q      <= S_HDR_HI;
            load_error_q <= 1'b0;
            words_q      <= '0;
            byte_idx_q   <= '0;
          end else begin
            load_error_q <= 1'b1;
          end
        end
        default: state_q <= S_HDR_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: header decode, word assembly/strobe timing,
// flow control, error/reload, mid-load reset and full-depth load.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        reload = 1'b0;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  words_loaded;
  logic        cpu_run;
  logic        load_error;

  int n_chk = 0;
  int n_fail = 0;
  logic [39:0] wq[$];

  program_loader #(.ADDR_WIDTH(8), .WORD_WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .words_loaded(words_loaded), .cpu_run(cpu_run),
    .load_error(load_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (imem_we === 1'b1) wq.push_back({imem_addr, imem_wdata});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  initial begin
    logic [7:0] prog [8];
    int bad;
    prog[0] = 8'h20; prog[1] = 8'h08; prog[2] = 8'h00; prog[3] = 8'h05;
    prog[4] = 8'h8C; prog[5] = 8'h09; prog[6] = 8'h00; prog[7] = 8'h04;

    // 1: reset
    #1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_we", imem_we, 0);
      chk("rst_outs", {imem_addr, imem_wdata, words_loaded, cpu_run, load_error}, 0);
      chk("rst_ready", in_ready, 1);
    end
    reset_n = 1'b1;
    tick();
    chk("idle_ready", in_ready, 1);

    // 2: N=2 stream, valid held high; exact strobe latency
    wq.delete();
    send(8'h00, 0); send(8'h02, 0);
    chk("hdr_no_we", imem_we, 0);
    for (int i = 0; i < 8; i++) begin
      send(prog[i], 0);
      if (i == 3) begin
        chk("w0_we", imem_we, 1);
        chk("w0_addr", imem_addr, 8'd0);
        chk("w0_data", imem_wdata, 32'h20080005);
        chk("w0_cnt", words_loaded, 9'd1);
      end else if (i == 7) begin
        chk("w1_we", imem_we, 1);
        chk("w1_addr", imem_addr, 8'd1);
        chk("w1_data", imem_wdata, 32'h8C090004);
        chk("w1_cnt", words_loaded, 9'd2);
        chk("w1_run_not_yet", cpu_run, 0);
        chk("w1_ready_low", in_ready, 0);
      end else begin
        chk("mid_no_we", imem_we, 0);
      end
    end
    tick();
    chk("run_high", cpu_run, 1);
    chk("run_we_low", imem_we, 0);
    chk("hold_addr_data", {imem_addr, imem_wdata}, {8'd1, 32'h8C090004});
    send(8'hFF, 1);
    chk("done_ignore", {words_loaded, cpu_run, in_ready}, {9'd2, 1'b1, 1'b0});
    chk("t2_nwrites", wq.size(), 2);
    pulse_reload();
    chk("reload_clear", {cpu_run, load_error, words_loaded, in_ready}, {1'b0, 1'b0, 9'd0, 1'b1});

    // 3: same stream with valid toggled
    wq.delete();
    send(8'h00, 1); send(8'h02, 1);
    for (int i = 0; i < 8; i++) send(prog[i], 1);
    tick();
    chk("t3_nwrites", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("t3_w0", wq[0], {8'd0, 32'h20080005});
      chk("t3_w1", wq[1], {8'd1, 32'h8C090004});
    end
    chk("t3_run", {cpu_run, words_loaded}, {1'b1, 9'd2});
    pulse_reload();

    // 4: N=0
    wq.delete();
    send(8'h00, 0); send(8'h00, 0);
    chk("n0_c1", {cpu_run, in_ready}, {1'b0, 1'b0});
    tick();
    chk("n0_c2_run", cpu_run, 1);
    chk("n0_no_we", wq.size(), 0);
    pulse_reload();

    // 5: N=257 -> error, then reload and N=1
    send(8'h01, 0); send(8'h01, 0);
    tick();
    chk("err", {load_error, cpu_run, in_ready}, {1'b1, 1'b0, 1'b0});
    send(8'h00, 1);
    chk("err_hold", {load_error, words_loaded, imem_we}, {1'b1, 9'd0, 1'b0});
    pulse_reload();
    chk("err_reload", {load_error, in_ready}, {1'b0, 1'b1});
    wq.delete();
    send(8'h00, 0); send(8'h01, 0);
    send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 0);
    chk("t5_write", {imem_we, imem_addr, imem_wdata}, {1'b1, 8'd0, 32'hDEADBEEF});
    tick();
    chk("t5_run", {cpu_run, load_error}, {1'b1, 1'b0});
    pulse_reload();

    // 6: reset mid-load drops the partial word
    send(8'h00, 0); send(8'h03, 0); send(8'hAA, 0); send(8'hBB, 0);
    reset_n = 1'b0;
    reload  = 1'b1;
    tick();
    reload  = 1'b0;
    chk("t6_rst", {imem_addr, imem_wdata, words_loaded, cpu_run, load_error, in_ready},
        {8'd0, 32'd0, 9'd0, 1'b0, 1'b0, 1'b1});
    reset_n = 1'b1;
    wq.delete();
    send(8'h00, 0); send(8'h01, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    tick();
    chk("t6_nwrites", wq.size(), 1);
    if (wq.size() == 1) chk("t6_w0", wq[0], {8'd0, 32'h11223344});
    chk("t6_run", cpu_run, 1);
    pulse_reload();

    // 7: N=256 fills the whole memory
    wq.delete();
    send(8'h01, 0); send(8'h00, 0);
    chk("n256_not_err", {load_error, in_ready}, {1'b0, 1'b1});
    for (int w = 0; w < 256; w++) begin
      send(8'(w), 0); send(8'(~w), 0); send(8'hA5, 0); send(8'(w + 3), 0);
    end
    chk("n256_last", {imem_we, imem_addr, words_loaded}, {1'b1, 8'd255, 9'd256});
    tick();
    chk("n256_run", {cpu_run, load_error}, {1'b1, 1'b0});
    chk("n256_nwrites", wq.size(), 256);
    bad = 0;
    for (int w = 0; w < wq.size(); w++)
      if (wq[w] !== {8'(w), 8'(w), 8'(~w), 8'hA5, 8'(w + 3)}) bad++;
    chk("n256_contents", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
